// File: rtl/dsp_mac_arb_pkg.sv
// Shared types and widths for the DSP MAC arbiter slice.
// OP_W/ACC_W are the DSP operand and accumulator widths.
// ID_W is sized for the largest supported requester count (8).
// tag_t travels alongside each operation through the DSP pipe.
package dsp_mac_arb_pkg;

  localparam int OP_W  = 18;
  localparam int ACC_W = 48;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HELD
  } arb_state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/dsp_mac_arbiter_if.sv
// Request/response bus of the DSP MAC arbiter.
//   req_valid/req_ready : per-requester handshake (ready is the grant)
//   req_a/b/d/c         : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_p        : requester id and result of the head response
// slave  : arbiter side
// master : requester/consumer side
interface dsp_mac_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import dsp_mac_arb_pkg::*;

  localparam int RID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*OP_W-1:0]  req_a;
  logic [NUM_REQ*OP_W-1:0]  req_b;
  logic [NUM_REQ*OP_W-1:0]  req_d;
  logic [NUM_REQ*ACC_W-1:0] req_c;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [RID_W-1:0]         rsp_id;
  logic [ACC_W-1:0]         rsp_p;

  modport slave (
    input  req_valid, req_a, req_b, req_d, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req_valid, req_a, req_b, req_d, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/dsp_mac_arb_rsp_fifo.sv
// In-order response FIFO holding {id, p} entries.
//   wr_en/wr_id/wr_p : capture port (never written when full; credits ensure it)
//   rd_en            : pop head (only asserted when count != 0)
//   rd_id/rd_p       : head entry, forced to zero while empty
//   count            : number of stored entries
module dsp_mac_arb_rsp_fifo
  import dsp_mac_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ID_W-1:0]  wr_id,
  input  logic [ACC_W-1:0] wr_p,
  input  logic             rd_en,
  output logic [ID_W-1:0]  rd_id,
  output logic [ACC_W-1:0] rd_p,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W+ACC_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_id, wr_p};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset, so the head is masked while empty.
  assign {rd_id, rd_p} = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dsp_mac_arbiter.sv
// Shares one pipelined DSP MAC (P = (A+B)*D + C) among NUM_REQ requesters.
// Round-robin combinational grant, registered operand issue, id tags
// shifted alongside the DSP pipe, in-order response FIFO with credits,
// and a hold/drain FSM that quiesces the DSP.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   bus (slave)        : request and response handshakes
//   dsp_a/b/d/c        : registered operands to the DSP
//   dsp_p              : DSP result, valid PIPE_LAT edges after issue
//   hold / hold_ack    : quiesce request / no ops in flight, granting stopped
//   stat_issued/stall  : only with DSP_MAC_ARB_STATS_EN defined
module dsp_mac_arbiter
  import dsp_mac_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PIPE_LAT  = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dsp_mac_arbiter_if.slave   bus,
  output logic [OP_W-1:0]    dsp_a,
  output logic [OP_W-1:0]    dsp_b,
  output logic [OP_W-1:0]    dsp_d,
  output logic [ACC_W-1:0]   dsp_c,
  input  logic [ACC_W-1:0]   dsp_p,
  input  logic               hold,
  output logic               hold_ack
`ifdef DSP_MAC_ARB_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall
`endif
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_id;
  logic               xfer;
  logic               pop;
  logic               pipe_busy;
  logic [CNT_W-1:0]   outstanding;
  tag_t               tags [PIPE_LAT];

  logic [OP_W-1:0]    sel_a, sel_b, sel_d;
  logic [ACC_W-1:0]   sel_c;

  logic [ID_W-1:0]    fifo_id;
  logic [ACC_W-1:0]   fifo_p;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_id_bits;

  // Round-robin search starting at rr_ptr, which holds last-granted+1.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    if (state == RUN && outstanding < CNT_W'(RSP_DEPTH)) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!found && bus.req_valid[idx]) begin
          grant[idx] = 1'b1;
          gnt_id     = idx;
          found      = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign xfer          = |grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_d = '0;
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*OP_W +: OP_W];
        sel_b = bus.req_b[i*OP_W +: OP_W];
        sel_d = bus.req_d[i*OP_W +: OP_W];
        sel_c = bus.req_c[i*ACC_W +: ACC_W];
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned k = 0; k < PIPE_LAT; k++) pipe_busy |= tags[k].vld;
  end

  // Operand issue, tag pipe and credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      dsp_a       <= '0;
      dsp_b       <= '0;
      dsp_d       <= '0;
      dsp_c       <= '0;
      outstanding <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) tags[k] <= '0;
    end else begin
      if (xfer) begin
        dsp_a  <= sel_a;
        dsp_b  <= sel_b;
        dsp_d  <= sel_d;
        dsp_c  <= sel_c;
        rr_ptr <= (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      tags[0] <= '{vld: xfer, id: ID_W'(gnt_id)};
      for (int unsigned k = 1; k < PIPE_LAT; k++) tags[k] <= tags[k-1];
      case ({xfer, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  // hold_ack is set on exactly the transitions into HELD, so it tracks the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      hold_ack <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          hold_ack <= 1'b0;
          if (hold) state <= DRAIN;
        end
        DRAIN: begin
          if (!hold) begin
            state    <= RUN;
            hold_ack <= 1'b0;
          end else if (!pipe_busy) begin
            state    <= HELD;
            hold_ack <= 1'b1;
          end else begin
            hold_ack <= 1'b0;
          end
        end
        HELD: begin
          if (!hold) begin
            state    <= RUN;
            hold_ack <= 1'b0;
          end else begin
            hold_ack <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          hold_ack <= 1'b0;
        end
      endcase
    end
  end

  dsp_mac_arb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (tags[PIPE_LAT-1].vld),
    .wr_id (tags[PIPE_LAT-1].id),
    .wr_p  (dsp_p),
    .rd_en (pop),
    .rd_id (fifo_id),
    .rd_p  (fifo_p),
    .count (fifo_count)
  );

  assign bus.rsp_valid = (fifo_count != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_id    = fifo_id[PTR_W-1:0];
  assign bus.rsp_p     = fifo_p;
  assign unused_id_bits = ^fifo_id;

`ifdef DSP_MAC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (xfer) stat_issued <= stat_issued + 32'd1;
      if ((|bus.req_valid) && !xfer) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_mac_arbiter.sv
// Directed bench for dsp_mac_arbiter with a behavioural PIPE_LAT-cycle DSP.
module tb_dsp_mac_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int PIPE_LAT  = 4;
  localparam int RSP_DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p;
  logic        hold, hold_ack;
`ifdef DSP_MAC_ARB_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  dsp_mac_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  dsp_mac_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .PIPE_LAT  (PIPE_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dsp_a    (dsp_a),
    .dsp_b    (dsp_b),
    .dsp_d    (dsp_d),
    .dsp_c    (dsp_c),
    .dsp_p    (dsp_p),
    .hold     (hold),
    .hold_ack (hold_ack)
`ifdef DSP_MAC_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External DSP: result appears PIPE_LAT edges after the operand register edge.
  logic [47:0] dsp_pipe [PIPE_LAT-1];
  always @(posedge clk) begin
    dsp_pipe[0] <= ((48'(dsp_a) + 48'(dsp_b)) * 48'(dsp_d)) + dsp_c;
    for (int k = 1; k < PIPE_LAT - 1; k++) dsp_pipe[k] <= dsp_pipe[k-1];
  end
  assign dsp_p = dsp_pipe[PIPE_LAT-2];

  typedef struct {
    logic [1:0]  id;
    logic [47:0] p;
  } rsp_t;
  rsp_t rq[$];

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready)
      rq.push_back('{id: bus.rsp_id, p: bus.rsp_p});
  end

  typedef struct {
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic [47:0] exp_p;
  } op_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } gvec_t;

  op_t   op_tab [4];
  gvec_t g_tab  [8];

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b,
                        input logic [17:0] d, input logic [47:0] c);
    bus.req_a[i*18 +: 18] = a;
    bus.req_b[i*18 +: 18] = b;
    bus.req_d[i*18 +: 18] = d;
    bus.req_c[i*48 +: 48] = c;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_d     = '0;
    bus.req_c     = '0;
    bus.rsp_ready = 1'b0;
    hold          = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rq.delete();
  endtask

  task automatic wait_rsp(input int n, input string name);
    int cyc = 0;
    while (rq.size() < n && cyc < 40) begin
      tick();
      cyc++;
    end
    check(name, 64'(rq.size()), 64'(n));
  endtask

  task automatic check_idle();
    check("rst_req_ready", 64'(bus.req_ready), 0);
    check("rst_dsp_a", 64'(dsp_a), 0);
    check("rst_dsp_b", 64'(dsp_b), 0);
    check("rst_dsp_d", 64'(dsp_d), 0);
    check("rst_dsp_c", 64'(dsp_c), 0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    check("rst_rsp_id", 64'(bus.rsp_id), 0);
    check("rst_rsp_p", 64'(bus.rsp_p), 0);
    check("rst_hold_ack", 64'(hold_ack), 0);
  endtask

  initial begin
    int lat;
    int acc;
    bit flag;

    op_tab[0] = '{a: 18'd5,       b: 18'd6,  d: 18'd3,       c: 48'd7,   exp_p: 48'd40};
    op_tab[1] = '{a: 18'd10,      b: 18'd20, d: 18'd4,       c: 48'd100, exp_p: 48'd220};
    op_tab[2] = '{a: 18'd1000,    b: 18'd24, d: 18'd1000,    c: 48'd5,   exp_p: 48'd1024005};
    op_tab[3] = '{a: 18'h3FFFF,   b: 18'd1,  d: 18'h3FFFF,   c: 48'd3,   exp_p: 48'h000F_FFFC_0003};

    g_tab[0] = '{valid: 4'b1010, exp_ready: 4'b0010};
    g_tab[1] = '{valid: 4'b1001, exp_ready: 4'b1000};
    g_tab[2] = '{valid: 4'b0110, exp_ready: 4'b0010};
    g_tab[3] = '{valid: 4'b0010, exp_ready: 4'b0010};
    g_tab[4] = '{valid: 4'b0000, exp_ready: 4'b0000};
    g_tab[5] = '{valid: 4'b0101, exp_ready: 4'b0100};
    g_tab[6] = '{valid: 4'b0001, exp_ready: 4'b0001};
    g_tab[7] = '{valid: 4'b1111, exp_ready: 4'b0010};

    // Reset state
    do_reset();
    check_idle();

    // Single op latency and result
    set_op(0, 18'd5, 18'd6, 18'd3, 48'd7);
    bus.req_valid = 4'b0001;
    #1;
    check("t1_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    check("t1_dsp_a", 64'(dsp_a), 5);
    check("t1_dsp_b", 64'(dsp_b), 6);
    check("t1_dsp_d", 64'(dsp_d), 3);
    check("t1_dsp_c", 64'(dsp_c), 7);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(PIPE_LAT + 1));
    check("t1_rsp_id", 64'(bus.rsp_id), 0);
    check("t1_rsp_p", 64'(bus.rsp_p), 40);
    check("t1_dsp_hold", 64'(dsp_a), 5);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t1_popped", 64'(bus.rsp_valid), 0);

    // All requesters valid: round-robin order and per-id results
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, op_tab[i].a, op_tab[i].b, op_tab[i].d, op_tab[i].c);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      tick();
    end
    bus.req_valid = '0;
    wait_rsp(8, "rr_rsp_count");
    for (int k = 0; k < 8; k++) begin
      check("rr_rsp_id", 64'(rq[k].id), 64'(k % 4));
      check("rr_rsp_p", 64'(rq[k].p), 64'(op_tab[k % 4].exp_p));
    end

    // Grant table with skipped and dropped requesters
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = g_tab[k].valid;
      #1;
      check("gtab_ready", 64'(bus.req_ready), 64'(g_tab[k].exp_ready));
      tick();
    end
    bus.req_valid = '0;

    // Credit exhaustion with the consumer stalled
    do_reset();
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      set_op(0, 18'(acc), 18'd1, 18'd2, 48'(acc));
      bus.req_valid = 4'b0001;
      #1;
      if (bus.req_ready[0]) acc++;
      tick();
    end
    check("full_accepts", 64'(acc), 64'(RSP_DEPTH));
    check("full_ready", 64'(bus.req_ready), 0);
    check("full_rsp_valid", 64'(bus.rsp_valid), 1);
    check("full_head", 64'(bus.rsp_p), 2);
    set_op(0, 18'd8, 18'd1, 18'd2, 48'd8);
    bus.rsp_ready = 1'b1;
    #1;
    check("full_nogrant", 64'(bus.req_ready), 0);
    tick();
    check("credit_resume", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    wait_rsp(9, "full_rsp_count");
    for (int k = 0; k < 9; k++) check("full_order", 64'(rq[k].p), 64'(3 * k + 2));

    // Hold with three ops in flight
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_op(0, 18'(k), 18'd1, 18'd2, 48'(k));
      bus.req_valid = 4'b0001;
      tick();
    end
    bus.req_valid = '0;
    hold = 1'b1;
    lat = 0;
    flag = 1'b0;
    while (!hold_ack && lat < 20) begin
      tick();
      lat++;
      bus.req_valid = 4'b0001;
      #1;
      if (bus.req_ready != '0) flag = 1'b1;
    end
    check("hold_ack_lat", 64'(lat), 64'(PIPE_LAT + 1));
    check("drain_nogrant", 64'(flag), 0);
    hold = 1'b0;
    #1;
    check("held_nogrant", 64'(bus.req_ready), 0);
    check("held_ack", 64'(hold_ack), 1);
    tick();
    check("release_ack", 64'(hold_ack), 0);
    check("release_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    wait_rsp(4, "hold_rsp_count");
    for (int k = 0; k < 3; k++) check("hold_rsp_p", 64'(rq[k].p), 64'(3 * k + 2));
    check("hold_rsp_last", 64'(rq[3].p), 8);

    // Reset with three in flight and two queued
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_op(0, 18'(k), 18'd1, 18'd2, 48'(k));
      bus.req_valid = 4'b0001;
      tick();
    end
    tick();
    check("pre_rst_valid", 64'(bus.rsp_valid), 1);
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_idle();
    tick();
    rst_n = 1'b1;
    rq.delete();
    bus.rsp_ready = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.rsp_valid) flag = 1'b1;
    end
    check("no_stale_rsp", 64'(flag), 0);
    set_op(0, 18'd2, 18'd2, 18'd2, 48'd2);
    bus.req_valid = 4'b0001;
    #1;
    check("post_rst_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    repeat (PIPE_LAT + 4) tick();
    check("post_rst_count", 64'(rq.size()), 1);
    check("post_rst_p", 64'(rq[0].p), 10);

`ifdef DSP_MAC_ARB_STATS_EN
    do_reset();
    check("stat_issued_rst", 64'(stat_issued), 0);
    check("stat_stall_rst", 64'(stat_stall), 0);
    bus.rsp_ready = 1'b1;
    set_op(0, 18'd1, 18'd1, 18'd1, 48'd1);
    bus.req_valid = 4'b0001;
    repeat (10) tick();
    bus.req_valid = '0;
    hold = 1'b1;
    tick();
    bus.req_valid = 4'b0001;
    repeat (4) tick();
    bus.req_valid = '0;
    hold = 1'b0;
    tick();
    tick();
    check("stat_issued", 64'(stat_issued), 10);
    check("stat_stall", 64'(stat_stall), 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
